param_dm_cache: RTL

Parametrised direct-mapped, write-through, no-write-allocate cache between the CPU load/store path and main data memory. Address split: tag | index | offset. Multi-word lines are filled from memory over a req/ack handshake. Adds valid bits, full-cache flush and saturating hit/miss counters for UART/LED debug readout.

---
 rtl/param_dm_cache.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/param_dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache between the CPU load/store
// path and main data memory. Multi-word line refill, full flush, and saturating hit/miss counters.
module param_dm_cache #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk_100,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              hit,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic [2:0]        dbg_state
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;
    localparam int DI_W  = INDEX_W + OFFSET_W;
    localparam int WC_W  = (OFFSET_W > 0) ? OFFSET_W : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FILL  = 3'd1;
    localparam logic [2:0] RESP  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] FLUSH = 3'd4;

    // Handshake: CPU request is taken on a rising edge where req_valid && req_ready;
    // resp_valid pulses for exactly one cycle per accepted request. Memory side:
    // mem_req holds (with stable address/data) until a one-cycle mem_ack per word.
    logic [2:0]         state;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic [WC_W-1:0]    word_ctr;
    logic [INDEX_W-1:0] flush_ctr;
    logic [LINES-1:0]   valid;
    logic               resp_q;

    logic [TAG_W-1:0]   tag_arr  [LINES];
    logic [DATA_W-1:0]  data_arr [LINES*WORDS];

    logic [TAG_W-1:0]   req_tag, lat_tag;
    logic [INDEX_W-1:0] req_idx, lat_idx;
    logic [DI_W-1:0]    req_di;
    logic [ADDR_W-1:0]  fill_addr;
    logic               lookup_hit, accept, fill_ack, last_word, write_done;

    assign req_tag    = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx    = req_addr[OFFSET_W +: INDEX_W];
    assign req_di     = req_addr[DI_W-1:0];
    assign lat_tag    = lat_addr[ADDR_W-1 -: TAG_W];
    assign lat_idx    = lat_addr[OFFSET_W +: INDEX_W];
    assign lookup_hit = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign accept     = (state == IDLE) && req_valid && !flush;
    // Line base of the latched address with the word counter in the offset field.
    assign fill_addr  = (lat_addr & ~ADDR_W'(WORDS - 1)) | ADDR_W'(word_ctr);
    assign fill_ack   = (state == FILL) && mem_ack;
    assign last_word  = (word_ctr == WC_W'(WORDS - 1));
    assign write_done = (state == WRITE) && mem_ack;

    assign req_ready  = (state == IDLE);
    assign resp_valid = resp_q || (state == RESP) || write_done;
    assign mem_req    = (state == FILL) || ((state == WRITE) && !mem_ack);
    assign mem_we     = (state == WRITE);
    assign mem_addr   = (state == FILL) ? fill_addr : (state == WRITE) ? lat_addr : '0;
    assign mem_wdata  = (state == WRITE) ? lat_wdata : '0;
    assign dbg_state  = state;

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            word_ctr   <= '0;
            flush_ctr  <= '0;
            valid      <= '0;
            resp_q     <= 1'b0;
            resp_rdata <= '0;
            hit        <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            resp_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        flush_ctr <= '0;
                        state     <= FLUSH;
                    end else if (req_valid) begin
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        hit       <= lookup_hit;
                        if (req_we) begin
                            state <= WRITE;
                        end else if (lookup_hit) begin
                            resp_q     <= 1'b1;
                            resp_rdata <= data_arr[req_di];
                            if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                        end else begin
                            if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
                            valid[req_idx] <= 1'b0;
                            word_ctr       <= '0;
                            state          <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        if (fill_addr == lat_addr) resp_rdata <= mem_rdata;
                        word_ctr <= word_ctr + WC_W'(1);
                        if (last_word) begin
                            valid[lat_idx] <= 1'b1;
                            state          <= RESP;
                        end
                    end
                end
                RESP:  state <= IDLE;
                WRITE: if (mem_ack) state <= IDLE;
                FLUSH: begin
                    valid[flush_ctr] <= 1'b0;
                    flush_ctr        <= flush_ctr + INDEX_W'(1);
                    if (flush_ctr == INDEX_W'(LINES - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data storage carries no reset; valid bits alone define the contents.
    always_ff @(posedge clk_100) begin
        if (accept && req_we && lookup_hit) data_arr[req_di] <= req_wdata;
        if (fill_ack) begin
            data_arr[fill_addr[DI_W-1:0]] <= mem_rdata;
            if (last_word) tag_arr[lat_idx] <= lat_tag;
        end
    end
endmodule
